// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared constants for the serial shift register family
`timescale 1ns/1ps
package shift_reg_pkg;
  localparam int   SHIFT_REG4_DEPTH  = 4;
  localparam logic SHIFT_REG_RST_VAL = 1'b0;
endpackage

// File: rtl/shift_reg_stage.sv
// shift_reg_stage: single D flop with synchronous active-high reset
`timescale 1ns/1ps
module shift_reg_stage
  import shift_reg_pkg::*;
#(
  parameter logic RST_VAL = SHIFT_REG_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic q_d, q_q;
  always_comb q_d = d;
  always_ff @(posedge clk) q_q <= rst ? RST_VAL : q_d;
  assign q = q_q;
endmodule

// File: rtl/shift_reg4.sv
// shift_reg4: serial-in/serial-out delay line of DEPTH flops, dout straight from the last stage
`timescale 1ns/1ps
module shift_reg4
  import shift_reg_pkg::*;
#(
  parameter int   DEPTH   = SHIFT_REG4_DEPTH,
  parameter logic RST_VAL = SHIFT_REG_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [DEPTH:0] chain;
  assign chain[0] = din;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    shift_reg_stage #(.RST_VAL(RST_VAL)) u_stage (
      .clk(clk),
      .rst(rst),
      .d  (chain[i]),
      .q  (chain[i+1])
    );
  end
  assign dout = chain[DEPTH];
endmodule

// File: tb/tb_shift_reg4.sv
// tb_shift_reg4: directed and randomized checks of shift_reg4 against a queue-based delay model
`timescale 1ns/1ps
module tb_shift_reg4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout;
  int n_asrt = 0;
  int n_fail = 0;
  logic exp_q[$] = '{1'bx, 1'bx, 1'bx, 1'bx};

  shift_reg4 dut (.clk(clk), .rst(rst), .din(din), .dout(dout));

  always #15 clk = ~clk;

  // Reference: a 4-entry FIFO of sampled bits; reset refills it with zeros
  always @(posedge clk) begin
    if (rst) exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    else begin
      exp_q.push_front(din);
      void'(exp_q.pop_back());
    end
  end

  task automatic chk_model(input string tag);
    n_asrt++;
    assert (dout === exp_q[3]) else begin
      n_fail++;
      $error("FAIL %s model: dout=%b expected %b", tag, dout, exp_q[3]);
    end
  endtask

  task automatic chk(input logic e, input string tag);
    n_asrt++;
    assert (dout === e) else begin
      n_fail++;
      $error("FAIL %s: dout=%b expected %b", tag, dout, e);
    end
    chk_model(tag);
  endtask

  task automatic cyc(input logic d, input logic r);
    din = d;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pat_in[8]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic pat_exp[8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    logic held;
    // Asynchronous din toggling every 12 ns, reset straddling the 15 ns edge
    din = 1'b1;
    fork
      for (int k = 0; k < 16; k++) #12 din = ~din;
      begin #10 rst = 1'b1; #10 rst = 1'b0; end
    join_none
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_model("async_din");
    end
    #25;
    @(posedge clk);
    #1;
    // Reset clears a preloaded 1111, then 1s take four edges to emerge
    for (int k = 0; k < 4; k++) cyc(1, 0);
    cyc(1, 1);
    chk(0, "rst_clear");
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0);
      chk(0, "rst_clear_hold");
    end
    cyc(1, 0);
    chk(1, "rst_clear_first1");
    // Pattern 1,0,1,1 followed by zeros
    cyc(0, 1);
    chk(0, "pat_rst");
    for (int k = 0; k < 8; k++) begin
      cyc(pat_in[k], 0);
      chk(pat_exp[k], "pattern");
    end
    // Single pulse
    cyc(0, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc(k == 1, 0);
      chk(k == 4, "pulse");
    end
    // Reset held three edges with din=1
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1);
      chk(0, "long_rst");
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0);
      chk(k == 4, "long_rst_release");
    end
    // Random stream with occasional resets
    for (int k = 0; k < 60; k++) begin
      cyc(1'($urandom), $urandom_range(0, 9) == 0);
      chk_model("random");
    end
    // Reset glitch between edges must not disturb anything
    for (int k = 0; k < 4; k++) begin
      cyc(1'($urandom), 0);
      chk_model("glitch_fill");
    end
    held = dout;
    #5 rst = 1'b1;
    #5 rst = 1'b0;
    #5;
    chk(held, "glitch_between");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk_model("glitch_after");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
